line_readout_framer: RTL

Downstream consumer of the line buffer. It waits for the buffer's whole-line-ready flag and walks the buffer's read port over all pixels of the captured line. It packs each 10-bit pixel into two bytes, adds a two-byte header and a one-byte checksum, and streams the frame over a valid/ready byte interface to the UART transmitter. When the line has been sent, it releases the buffer through the buffer's reset-ready input so the next line can be recorded.

---
 rtl/line_readout_framer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/line_readout_framer.sv
// Line readout framer: walks a captured line out of the line buffer and
// streams it as a header, packed pixel bytes and a checksum over valid/ready.
module line_readout_framer #(
  parameter int V = 480,
  localparam int AW = (V > 1) ? $clog2(V) : 1
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          LINE_READY,
  output logic [AW-1:0] READ_ADDRESS,
  input  logic [9:0]    PIXEL_DATA,
  output logic          RESET_READY_FLAG,
  output logic [7:0]    TX_DATA,
  output logic          TX_VALID,
  input  logic          TX_READY,
  output logic          BUSY
);

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    FETCH,
    PIX_HI,
    PIX_LO,
    CSUM,
    RELEASE
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(V - 1);

  state_t     state;
  logic       fetch_cnt;
  logic [9:0] hold;
  logic [7:0] csum;
  logic       xfer;

  // A byte leaves only when the transmitter takes it.
  assign xfer = TX_VALID & TX_READY;

  // Frame sequencer; every output is a register updated here.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state            <= IDLE;
      fetch_cnt        <= 1'b0;
      hold             <= '0;
      csum             <= '0;
      READ_ADDRESS     <= '0;
      RESET_READY_FLAG <= 1'b0;
      TX_DATA          <= 8'h00;
      TX_VALID         <= 1'b0;
      BUSY             <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          READ_ADDRESS     <= '0;
          RESET_READY_FLAG <= 1'b0;
          if (LINE_READY) begin
            state    <= HDR0;
            TX_VALID <= 1'b1;
            TX_DATA  <= 8'hA5;
            BUSY     <= 1'b1;
            csum     <= '0;
          end
        end
        HDR0: begin
          if (xfer) begin
            state   <= HDR1;
            TX_DATA <= 8'h5A;
          end
        end
        HDR1: begin
          if (xfer) begin
            state     <= FETCH;
            TX_VALID  <= 1'b0;
            fetch_cnt <= 1'b0;
          end
        end
        FETCH: begin
          // First cycle lets the buffer register the new address.
          if (!fetch_cnt) begin
            fetch_cnt <= 1'b1;
          end else begin
            hold     <= PIXEL_DATA;
            state    <= PIX_HI;
            TX_VALID <= 1'b1;
            TX_DATA  <= {6'b0, PIXEL_DATA[9:8]};
          end
        end
        PIX_HI: begin
          if (xfer) begin
            csum    <= csum + {6'b0, hold[9:8]};
            TX_DATA <= hold[7:0];
            state   <= PIX_LO;
          end
        end
        PIX_LO: begin
          if (xfer) begin
            csum      <= csum + hold[7:0];
            fetch_cnt <= 1'b0;
            if (READ_ADDRESS < LAST) begin
              READ_ADDRESS <= READ_ADDRESS + 1'b1;
              state        <= FETCH;
              TX_VALID     <= 1'b0;
            end else begin
              state   <= CSUM;
              TX_DATA <= csum + hold[7:0];
            end
          end
        end
        CSUM: begin
          if (xfer) begin
            state            <= RELEASE;
            TX_VALID         <= 1'b0;
            RESET_READY_FLAG <= LINE_READY;
          end
        end
        RELEASE: begin
          // Hold the release request until the buffer drops its flag.
          if (LINE_READY) begin
            RESET_READY_FLAG <= 1'b1;
          end else begin
            RESET_READY_FLAG <= 1'b0;
            READ_ADDRESS     <= '0;
            BUSY             <= 1'b0;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
